// File: rtl/apb_fifo_pkg.sv
// Shared state encoding and command/response word helpers for the APB FIFO master.
package apb_fifo_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      SETUP  = 3'd2,
      ACCESS = 3'd3,
      RESP   = 3'd4
   } state_t;

   // Helpers operate on words widened to these maxima; callers cast to their real widths.
   localparam int MAX_ADDR_W = 32;
   localparam int MAX_DATA_W = 64;
   localparam int MAX_CMD_W  = 1 + MAX_ADDR_W + MAX_DATA_W;
   localparam int MAX_RSP_W  = 2 + MAX_DATA_W;

   function automatic int cmd_w(input int aw, input int dw);
      return 1 + aw + dw;
   endfunction

   function automatic int rsp_w(input int dw);
      return 2 + dw;
   endfunction

   function automatic logic [MAX_CMD_W-1:0] pack_cmd(input logic write,
                                                      input logic [MAX_ADDR_W-1:0] addr,
                                                      input logic [MAX_DATA_W-1:0] wdata,
                                                      input int aw, input int dw);
      return (MAX_CMD_W'(write) << (aw + dw)) | (MAX_CMD_W'(addr) << dw) | MAX_CMD_W'(wdata);
   endfunction

   function automatic logic cmd_write(input logic [MAX_CMD_W-1:0] word, input int aw, input int dw);
      return 1'(word >> (aw + dw));
   endfunction

   function automatic logic [MAX_ADDR_W-1:0] cmd_addr(input logic [MAX_CMD_W-1:0] word, input int dw);
      return MAX_ADDR_W'(word >> dw);
   endfunction

   function automatic logic [MAX_DATA_W-1:0] cmd_wdata(input logic [MAX_CMD_W-1:0] word);
      return MAX_DATA_W'(word);
   endfunction

   function automatic logic [MAX_RSP_W-1:0] pack_rsp(input logic timeout, input logic slverr,
                                                      input logic [MAX_DATA_W-1:0] rdata,
                                                      input int dw);
      return (MAX_RSP_W'(timeout) << (dw + 1)) | (MAX_RSP_W'(slverr) << dw) | MAX_RSP_W'(rdata);
   endfunction

   function automatic logic rsp_is_err(input logic [MAX_RSP_W-1:0] word, input int dw);
      return 1'(word >> dw) | 1'(word >> (dw + 1));
   endfunction

endpackage

// File: rtl/apb_fifo_master.sv
// APB master draining the bridge command FIFO: one pop, one APB transfer, one response push.
module apb_fifo_master
   import apb_fifo_pkg::*;
#(
   parameter int ADDR_WIDTH     = 16,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 256,
   localparam int CMD_W         = cmd_w(ADDR_WIDTH, DATA_WIDTH),
   localparam int RSP_W         = rsp_w(DATA_WIDTH)
) (
   input  logic                  rclk,
   input  logic                  reset,
   input  logic                  cmd_empty,
   output logic                  cmd_ren,
   input  logic [CMD_W-1:0]      cmd_rdata,
   input  logic                  rsp_full,
   output logic                  rsp_wen,
   output logic [RSP_W-1:0]      rsp_wdata,
   output logic                  psel,
   output logic                  penable,
   output logic                  pwrite,
   output logic [ADDR_WIDTH-1:0] paddr,
   output logic [DATA_WIDTH-1:0] pwdata,
   input  logic [DATA_WIDTH-1:0] prdata,
   input  logic                  pready,
   input  logic                  pslverr,
   output logic                  busy,
   output logic [15:0]           err_count
);

   localparam int TO_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

   state_t              state_r;
   logic [TO_W-1:0]     to_cnt_r;
   logic [MAX_CMD_W-1:0] cmd_word_s;

   assign cmd_word_s = MAX_CMD_W'(cmd_rdata);
   assign busy       = (state_r != IDLE);

   // FIFO strobes: pop only from IDLE, push only from RESP, both held off during reset.
   always_comb begin
      cmd_ren = 1'b0;
      rsp_wen = 1'b0;
      if (reset) begin
         cmd_ren = 1'b0;
         rsp_wen = 1'b0;
      end else begin
         cmd_ren = (state_r == IDLE) && !cmd_empty;
         rsp_wen = (state_r == RESP) && !rsp_full;
      end
   end

   // Transfer sequencer with registered APB outputs, timeout counter and error counter.
   always_ff @(posedge rclk) begin
      if (reset) begin
         state_r   <= IDLE;
         psel      <= 1'b0;
         penable   <= 1'b0;
         pwrite    <= 1'b0;
         paddr     <= '0;
         pwdata    <= '0;
         rsp_wdata <= '0;
         err_count <= 16'd0;
         to_cnt_r  <= '0;
      end else begin
         case (state_r)
            IDLE: begin
               if (!cmd_empty) state_r <= FETCH;
            end
            FETCH: begin
               pwrite  <= cmd_write(cmd_word_s, ADDR_WIDTH, DATA_WIDTH);
               paddr   <= ADDR_WIDTH'(cmd_addr(cmd_word_s, DATA_WIDTH));
               pwdata  <= DATA_WIDTH'(cmd_wdata(cmd_word_s));
               psel    <= 1'b1;
               state_r <= SETUP;
            end
            SETUP: begin
               penable  <= 1'b1;
               to_cnt_r <= '0;
               state_r  <= ACCESS;
            end
            ACCESS: begin
               if (pready) begin
                  rsp_wdata <= RSP_W'(pack_rsp(1'b0, pslverr,
                                               pwrite ? {MAX_DATA_W{1'b0}} : MAX_DATA_W'(prdata),
                                               DATA_WIDTH));
                  psel      <= 1'b0;
                  penable   <= 1'b0;
                  state_r   <= RESP;
               end else if (to_cnt_r == TO_LAST) begin
                  rsp_wdata <= RSP_W'(pack_rsp(1'b1, 1'b0, {MAX_DATA_W{1'b0}}, DATA_WIDTH));
                  psel      <= 1'b0;
                  penable   <= 1'b0;
                  state_r   <= RESP;
               end else begin
                  to_cnt_r <= to_cnt_r + TO_W'(1);
               end
            end
            RESP: begin
               if (!rsp_full) begin
                  if (rsp_is_err(MAX_RSP_W'(rsp_wdata), DATA_WIDTH) && (err_count != 16'hFFFF))
                     err_count <= err_count + 16'd1;
                  state_r <= IDLE;
               end
            end
            default: begin
               psel    <= 1'b0;
               penable <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_apb_fifo_master.sv
// Randomized bench for apb_fifo_master with FIFO/APB-slave models and a transfer-level reference.
module tb_apb_fifo_master;

   localparam int AW = 16;
   localparam int DW = 32;
   localparam int T  = 8;

   logic          rclk = 1'b0;
   logic          reset, cmd_empty, cmd_ren, rsp_full, rsp_wen;
   logic          psel, penable, pwrite, pready, pslverr, busy;
   logic [AW+DW:0] cmd_rdata;
   logic [DW+1:0] rsp_wdata;
   logic [AW-1:0] paddr;
   logic [DW-1:0] pwdata, prdata;
   logic [15:0]   err_count;

   always #5 rclk = ~rclk;

   apb_fifo_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(T)) dut (
      .rclk(rclk), .reset(reset), .cmd_empty(cmd_empty), .cmd_ren(cmd_ren),
      .cmd_rdata(cmd_rdata), .rsp_full(rsp_full), .rsp_wen(rsp_wen), .rsp_wdata(rsp_wdata),
      .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
      .prdata(prdata), .pready(pready), .pslverr(pslverr), .busy(busy), .err_count(err_count)
   );

   typedef struct {
      bit        write;
      bit [15:0] addr;
      bit [31:0] wdata;
      int        waits;   // slave wait states; >= T means the slave never answers
      bit        err;
      bit [31:0] rdata;
   } cmd_t;

   typedef struct {
      bit [15:0] addr;
      bit        write;
      bit [31:0] wdata;
      int        len;     // ACCESS cycles seen
      bit        stable;
   } xfer_t;

   logic [48:0] cmd_q[$];
   cmd_t        plan_q[$];
   cmd_t        exp_q[$];
   logic [33:0] obs_q[$];
   xfer_t       log_q[$];
   int          ren_cyc_q[$];
   int          wen_cyc_q[$];
   int          cyc = 0;
   int          tests = 0;
   int          fails = 0;
   int          exp_err = 0;
   logic [48:0] popped;
   bit          pop_pend = 1'b0;

   // Reference model: response and ACCESS length from the transfer rules.
   function automatic logic [33:0] model_rsp(cmd_t c);
      if (c.waits >= T) return {1'b1, 1'b0, 32'h0};
      return {1'b0, c.err, (c.write ? 32'h0 : c.rdata)};
   endfunction

   function automatic int model_len(cmd_t c);
      return (c.waits >= T) ? T : c.waits + 1;
   endfunction

   function automatic cmd_t mk(bit w, bit [15:0] a, bit [31:0] d, int waits, bit e, bit [31:0] r);
      cmd_t c;
      c.write = w; c.addr = a; c.wdata = d; c.waits = waits; c.err = e; c.rdata = r;
      return c;
   endfunction

   function automatic cmd_t rand_cmd(int max_waits);
      return mk(1'($urandom_range(0, 1)), 16'($urandom), $urandom, $urandom_range(0, max_waits),
                1'($urandom_range(0, 1)), $urandom);
   endfunction

   initial forever begin
      @(posedge rclk);
      cyc++;
   end

   // Command FIFO read side: registered data, flag updated after the edge.
   initial begin
      cmd_empty = 1'b1;
      cmd_rdata = '0;
      forever begin
         @(posedge rclk);
         #1;
         if (pop_pend) begin
            cmd_rdata = popped;
            pop_pend  = 1'b0;
         end
         cmd_empty = (cmd_q.size() == 0);
      end
   end

   initial forever begin
      @(negedge rclk);
      if (cmd_ren === 1'b1) begin
         ren_cyc_q.push_back(cyc);
         if (cmd_q.size() > 0) begin
            popped   = cmd_q.pop_front();
            pop_pend = 1'b1;
         end
      end
      if (rsp_wen === 1'b1) begin
         obs_q.push_back(rsp_wdata);
         wen_cyc_q.push_back(cyc);
      end
   end

   // APB slave following the per-command plan; noise on pslverr/prdata while not ready.
   initial begin
      cmd_t  cur;
      xfer_t cx;
      int    acc_cnt = 0;
      bit    in_acc = 1'b0;
      cur = mk(1'b0, 16'h0, 32'h0, 0, 1'b0, 32'h0);
      pready = 1'b0; pslverr = 1'b0; prdata = '0;
      forever begin
         @(negedge rclk);
         if (psel === 1'b1 && penable === 1'b0) begin
            if (plan_q.size() > 0) cur = plan_q.pop_front();
            else cur = mk(1'b0, 16'h0, 32'h0, 0, 1'b0, 32'h0);
            cx.addr = paddr; cx.write = pwrite; cx.wdata = pwdata; cx.len = 0; cx.stable = 1'b1;
            acc_cnt = 0;
            pready  = 1'b0;
         end else if (psel === 1'b1 && penable === 1'b1) begin
            in_acc = 1'b1;
            cx.len++;
            if (paddr !== cx.addr || pwrite !== cx.write || pwdata !== cx.wdata) cx.stable = 1'b0;
            if (acc_cnt == cur.waits) begin
               pready = 1'b1; pslverr = cur.err; prdata = cur.rdata;
            end else begin
               pready = 1'b0; pslverr = 1'($urandom_range(0, 1)); prdata = $urandom;
            end
            acc_cnt++;
         end else begin
            if (in_acc) begin
               log_q.push_back(cx);
               in_acc = 1'b0;
            end
            pready = 1'b0; pslverr = 1'b0; prdata = $urandom;
         end
      end
   end

   task automatic queue_cmd(input cmd_t c, input bit expect_rsp);
      plan_q.push_back(c);
      if (expect_rsp) exp_q.push_back(c);
      cmd_q.push_back({c.write, c.addr, c.wdata});
   endtask

   task automatic wait_rsp(input int n, input string name);
      int budget = 2000;
      while (obs_q.size() < n && budget > 0) begin
         @(posedge rclk);
         budget--;
      end
      tests++;
      if (obs_q.size() < n) begin
         fails++;
         $display("FAIL %s wait: got %0d responses, required %0d", name, obs_q.size(), n);
      end
   endtask

   task automatic next_result(output logic [33:0] got, output cmd_t c, output xfer_t x, output bit ok);
      logic [33:0] e;
      got = '0;
      c = mk(1'b0, 16'h0, 32'h0, 0, 1'b0, 32'h0);
      x.addr = 16'h0; x.write = 1'b0; x.wdata = 32'h0; x.len = 0; x.stable = 1'b0;
      ok = (obs_q.size() > 0) && (exp_q.size() > 0) && (log_q.size() > 0);
      if (ok) begin
         got = obs_q.pop_front();
         c   = exp_q.pop_front();
         x   = log_q.pop_front();
         e   = model_rsp(c);
         if ((e[33] || e[32]) && exp_err < 65535) exp_err++;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      rsp_full = 1'b0;
      repeat (3) @(posedge rclk);
      @(negedge rclk);
      tests++; if ({psel, penable, pwrite} !== 3'b000) begin fails++; $display("FAIL reset_ctrl: got %b required 000", {psel, penable, pwrite}); end
      tests++; if (paddr !== 16'h0 || pwdata !== 32'h0) begin fails++; $display("FAIL reset_addr_data: got %h/%h required 0/0", paddr, pwdata); end
      tests++; if (rsp_wdata !== 34'h0) begin fails++; $display("FAIL reset_rsp: got %h required 0", rsp_wdata); end
      tests++; if (err_count !== 16'h0 || busy !== 1'b0) begin fails++; $display("FAIL reset_cnt_busy: got %h/%b required 0/0", err_count, busy); end
      tests++; if ({cmd_ren, rsp_wen} !== 2'b00) begin fails++; $display("FAIL reset_strobes: got %b required 00", {cmd_ren, rsp_wen}); end
      @(posedge rclk);
      #1 reset = 1'b0;
   endtask

   task automatic test_write_zero_wait();
      logic [33:0] got; cmd_t c; xfer_t x; bit ok;
      ren_cyc_q.delete(); wen_cyc_q.delete();
      queue_cmd(mk(1'b1, 16'h0010, 32'hDEADBEEF, 0, 1'b0, 32'h0), 1'b1);
      wait_rsp(1, "write_zero_wait");
      @(negedge rclk);
      next_result(got, c, x, ok);
      tests++; if (!ok || got !== 34'h0) begin fails++; $display("FAIL write_rsp: got %h required 0", got); end
      tests++; if (x.addr !== 16'h0010 || x.wdata !== 32'hDEADBEEF || x.write !== 1'b1 || !x.stable) begin fails++; $display("FAIL write_apb: got %h/%h/%b required 0010/deadbeef/1", x.addr, x.wdata, x.write); end
      tests++; if (x.len + 1 != 2) begin fails++; $display("FAIL write_psel_cycles: got %0d required 2", x.len + 1); end
      tests++; if (ren_cyc_q.size() < 1 || wen_cyc_q.size() < 1 || wen_cyc_q[0] - ren_cyc_q[0] != 4) begin fails++; $display("FAIL write_latency: ren/wen sizes %0d/%0d, required latency 4", ren_cyc_q.size(), wen_cyc_q.size()); end
   endtask

   task automatic test_back_to_back();
      logic [33:0] got; cmd_t c; xfer_t x; bit ok;
      ren_cyc_q.delete(); wen_cyc_q.delete();
      queue_cmd(mk(1'b0, 16'h1111, 32'h0, 0, 1'b0, 32'hA5A5A5A5), 1'b1);
      queue_cmd(mk(1'b0, 16'h2222, 32'h0, 0, 1'b0, 32'h5A5A5A5A), 1'b1);
      wait_rsp(2, "back_to_back");
      @(negedge rclk);
      for (int i = 0; i < 2; i++) begin
         next_result(got, c, x, ok);
         tests++; if (!ok || got !== model_rsp(c) || x.addr !== c.addr) begin fails++; $display("FAIL b2b_rsp%0d: got %h@%h required %h@%h", i, got, x.addr, model_rsp(c), c.addr); end
      end
      tests++; if (ren_cyc_q.size() != 2 || ren_cyc_q[1] - ren_cyc_q[0] != 5) begin fails++; $display("FAIL b2b_pop_spacing: got %0d pops, required 2 pops 5 cycles apart", ren_cyc_q.size()); end
      tests++; if (wen_cyc_q.size() != 2 || wen_cyc_q[1] - wen_cyc_q[0] != 5) begin fails++; $display("FAIL b2b_push_spacing: got %0d pushes, required 2 pushes 5 cycles apart", wen_cyc_q.size()); end
   endtask

   task automatic test_read_waits();
      logic [33:0] got; cmd_t c; xfer_t x; bit ok;
      queue_cmd(mk(1'b0, 16'h0020, 32'h0, 3, 1'b0, 32'h12345678), 1'b1);
      wait_rsp(1, "read_waits");
      @(negedge rclk);
      next_result(got, c, x, ok);
      tests++; if (!ok || got !== {2'b00, 32'h12345678}) begin fails++; $display("FAIL read_rsp: got %h required 012345678", got); end
      tests++; if (x.len != 4 || x.addr !== 16'h0020 || x.write !== 1'b0 || !x.stable) begin fails++; $display("FAIL read_access: got len %0d addr %h required 4/0020", x.len, x.addr); end
   endtask

   task automatic test_slverr();
      logic [33:0] got; cmd_t c; xfer_t x; bit ok;
      queue_cmd(mk(1'b0, 16'h0030, 32'h0, 1, 1'b1, $urandom), 1'b1);
      wait_rsp(1, "slverr");
      @(negedge rclk);
      next_result(got, c, x, ok);
      tests++; if (!ok || got !== model_rsp(c)) begin fails++; $display("FAIL slverr_rsp: got %h required %h", got, model_rsp(c)); end
      tests++; if (err_count !== 16'(exp_err) || exp_err != 1) begin fails++; $display("FAIL slverr_count: got %0d required 1", err_count); end
   endtask

   task automatic test_timeout();
      logic [33:0] got; cmd_t c; xfer_t x; bit ok;
      queue_cmd(mk(1'b0, 16'h0040, 32'h0, T + $urandom_range(0, 5), 1'b1, $urandom), 1'b1);
      queue_cmd(mk(1'b0, 16'h0050, 32'h0, T - 1, 1'b1, $urandom), 1'b1);
      wait_rsp(2, "timeout");
      @(negedge rclk);
      next_result(got, c, x, ok);
      tests++; if (!ok || got !== {1'b1, 1'b0, 32'h0}) begin fails++; $display("FAIL timeout_rsp: got %h required 200000000", got); end
      tests++; if (x.len != T) begin fails++; $display("FAIL timeout_len: got %0d required %0d", x.len, T); end
      next_result(got, c, x, ok);
      tests++; if (!ok || got !== model_rsp(c)) begin fails++; $display("FAIL last_cycle_ready_rsp: got %h required %h", got, model_rsp(c)); end
      tests++; if (x.len != T) begin fails++; $display("FAIL last_cycle_ready_len: got %0d required %0d", x.len, T); end
      tests++; if (err_count !== 16'(exp_err)) begin fails++; $display("FAIL timeout_count: got %0d required %0d", err_count, exp_err); end
   endtask

   task automatic test_backpressure();
      logic [33:0] got; cmd_t c; xfer_t x; bit ok;
      @(posedge rclk);
      #1 rsp_full = 1'b1;
      ren_cyc_q.delete();
      for (int i = 0; i < 4; i++) queue_cmd(rand_cmd(2), 1'b1);
      repeat (20) @(posedge rclk);
      @(negedge rclk);
      tests++; if (ren_cyc_q.size() != 1) begin fails++; $display("FAIL full_pops: got %0d required 1", ren_cyc_q.size()); end
      tests++; if (obs_q.size() != 0 || busy !== 1'b1) begin fails++; $display("FAIL full_hold: got %0d pushes busy %b required 0/1", obs_q.size(), busy); end
      @(posedge rclk);
      #1 rsp_full = 1'b0;
      wait_rsp(4, "backpressure");
      @(negedge rclk);
      for (int i = 0; i < 4; i++) begin
         next_result(got, c, x, ok);
         tests++; if (!ok || got !== model_rsp(c) || x.addr !== c.addr || x.len != model_len(c)) begin fails++; $display("FAIL full_order%0d: got %h@%h required %h@%h", i, got, x.addr, model_rsp(c), c.addr); end
      end
      tests++; if (ren_cyc_q.size() != 4 || err_count !== 16'(exp_err)) begin fails++; $display("FAIL full_drain: got %0d pops err %0d required 4/%0d", ren_cyc_q.size(), err_count, exp_err); end
   endtask

   task automatic test_reset_mid();
      logic [33:0] got; cmd_t c; xfer_t x; bit ok;
      int budget = 100;
      int n0;
      n0 = obs_q.size();
      queue_cmd(mk(1'b1, 16'h0BAD, 32'hBAADF00D, 6, 1'b0, 32'h0), 1'b0);
      queue_cmd(mk(1'b0, 16'h0060, 32'h0, 2, 1'b0, 32'hCAFEF00D), 1'b1);
      while (!(psel === 1'b1 && penable === 1'b1) && budget > 0) begin
         @(negedge rclk);
         budget--;
      end
      tests++; if (budget == 0) begin fails++; $display("FAIL reset_mid_access: ACCESS not reached, required within 100 cycles"); end
      @(posedge rclk);
      #1 reset = 1'b1;
      @(posedge rclk);
      @(negedge rclk);
      tests++; if (psel !== 1'b0 || penable !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL reset_mid_apb: got psel %b penable %b busy %b required 0/0/0", psel, penable, busy); end
      tests++; if (cmd_empty !== 1'b0 || cmd_ren !== 1'b0 || rsp_wen !== 1'b0) begin fails++; $display("FAIL reset_mid_strobes: got empty %b ren %b wen %b required 0/0/0", cmd_empty, cmd_ren, rsp_wen); end
      @(posedge rclk);
      #1 reset = 1'b0;
      exp_err = 0;
      @(negedge rclk);
      log_q.delete();
      tests++; if (obs_q.size() != n0) begin fails++; $display("FAIL reset_mid_no_push: got %0d responses required %0d", obs_q.size(), n0); end
      wait_rsp(1, "reset_mid_next");
      @(negedge rclk);
      next_result(got, c, x, ok);
      tests++; if (!ok || got !== {2'b00, 32'hCAFEF00D} || x.addr !== 16'h0060 || x.len != 3) begin fails++; $display("FAIL reset_mid_next_rsp: got %h@%h len %0d required 0cafef00d@0060 len 3", got, x.addr, x.len); end
      tests++; if (err_count !== 16'h0) begin fails++; $display("FAIL reset_mid_count: got %0d required 0", err_count); end
   endtask

   task automatic test_random();
      logic [33:0] got; cmd_t c; xfer_t x; bit ok;
      int budget = 3000;
      for (int i = 0; i < 25; i++) queue_cmd(rand_cmd(T + 1), 1'b1);
      while (obs_q.size() < 25 && budget > 0) begin
         @(posedge rclk);
         #1 rsp_full = ($urandom_range(0, 3) == 0);
         budget--;
      end
      rsp_full = 1'b0;
      wait_rsp(25, "random");
      @(negedge rclk);
      for (int i = 0; i < 25; i++) begin
         next_result(got, c, x, ok);
         tests++; if (!ok || got !== model_rsp(c)) begin fails++; $display("FAIL rand_rsp%0d: got %h required %h", i, got, model_rsp(c)); end
         tests++; if (x.addr !== c.addr || x.write !== c.write || x.wdata !== c.wdata || !x.stable || x.len != model_len(c)) begin fails++; $display("FAIL rand_apb%0d: got %h/%b/%h len %0d required %h/%b/%h len %0d", i, x.addr, x.write, x.wdata, x.len, c.addr, c.write, c.wdata, model_len(c)); end
      end
      tests++; if (err_count !== 16'(exp_err)) begin fails++; $display("FAIL rand_count: got %0d required %0d", err_count, exp_err); end
   endtask

   initial begin
      reset = 1'b1;
      rsp_full = 1'b0;
      test_reset();
      test_write_zero_wait();
      test_back_to_back();
      test_read_waits();
      test_slverr();
      test_timeout();
      test_backpressure();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
